// File: rtl/frame_sequencer.sv
// Pixel-array frame sequencer: erase, expose, convert, then four row reads, with a gap cycle after each phase.
// Optional ADC ramp counter on adc_count is enabled by defining FRAME_SEQ_ADC_RAMP_EN.
module frame_sequencer #(
    parameter logic [7:0] DEF_ERASE   = 8'd5,
    parameter logic [7:0] DEF_EXPOSE  = 8'd255,
    parameter logic [7:0] DEF_CONVERT = 8'd255,
    parameter logic [7:0] DEF_READ    = 8'd1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_we,
    input  logic [1:0] cfg_addr,
    input  logic [7:0] cfg_wdata,
    input  logic       start,
    input  logic       stop,
    input  logic       continuous,
    output logic       erase,
    output logic       expose,
    output logic       convert,
    output logic [3:0] read,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] frame_cnt,
    output logic [7:0] adc_count
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_ERASE   = 4'd1;
    localparam logic [3:0] S_EXPOSE  = 4'd2;
    localparam logic [3:0] S_CONVERT = 4'd3;
    localparam logic [3:0] S_READ1   = 4'd4;
    localparam logic [3:0] S_READ2   = 4'd5;
    localparam logic [3:0] S_READ3   = 4'd6;
    localparam logic [3:0] S_READ4   = 4'd7;
    localparam logic [3:0] S_GAP     = 4'd8;

    logic [3:0] state, next_state, last_phase;
    logic [7:0] cnt, load_val;
    logic       load_en, frame_start, done_next;
    logic [7:0] stg_erase, stg_expose, stg_convert, stg_read;
    logic [7:0] sh_expose, sh_convert, sh_read;

    function automatic logic [7:0] dur_m1(input logic [7:0] d);
        return (d == 8'd0) ? 8'd0 : d - 8'd1;
    endfunction

    always_comb begin
        next_state  = state;
        load_en     = 1'b0;
        load_val    = 8'd0;
        frame_start = 1'b0;
        done_next   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !stop) begin
                    next_state  = S_ERASE;
                    frame_start = 1'b1;
                    load_en     = 1'b1;
                    load_val    = stg_erase;
                end
            end
            S_ERASE, S_EXPOSE, S_CONVERT, S_READ1, S_READ2, S_READ3, S_READ4: begin
                if (cnt == 8'd0) begin
                    next_state = S_GAP;
                    done_next  = (state == S_READ4);
                end
            end
            S_GAP: begin
                load_en = 1'b1;
                case (last_phase)
                    S_ERASE:   begin next_state = S_EXPOSE;  load_val = sh_expose;  end
                    S_EXPOSE:  begin next_state = S_CONVERT; load_val = sh_convert; end
                    S_CONVERT: begin next_state = S_READ1;   load_val = sh_read;    end
                    S_READ1:   begin next_state = S_READ2;   load_val = sh_read;    end
                    S_READ2:   begin next_state = S_READ3;   load_val = sh_read;    end
                    S_READ3:   begin next_state = S_READ4;   load_val = sh_read;    end
                    default: begin
                        if (continuous) begin
                            next_state  = S_ERASE;
                            frame_start = 1'b1;
                            load_val    = stg_erase;
                        end else begin
                            next_state = S_IDLE;
                            load_en    = 1'b0;
                        end
                    end
                endcase
            end
            default: next_state = S_IDLE;
        endcase
        // stop overrides everything, including a continuous restart
        if (stop && state != S_IDLE) begin
            next_state  = S_IDLE;
            load_en     = 1'b0;
            frame_start = 1'b0;
            done_next   = 1'b0;
        end
    end

    // Erase duration is taken straight from staging at frame start, so it needs no shadow copy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            last_phase  <= S_IDLE;
            cnt         <= 8'd0;
            stg_erase   <= DEF_ERASE;
            stg_expose  <= DEF_EXPOSE;
            stg_convert <= DEF_CONVERT;
            stg_read    <= DEF_READ;
            sh_expose   <= DEF_EXPOSE;
            sh_convert  <= DEF_CONVERT;
            sh_read     <= DEF_READ;
            erase       <= 1'b0;
            expose      <= 1'b0;
            convert     <= 1'b0;
            read        <= 4'd0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_cnt   <= 8'd0;
        end else begin
            state <= next_state;
            if (state != S_GAP && state != S_IDLE)
                last_phase <= state;
            if (load_en)
                cnt <= dur_m1(load_val);
            else if (cnt != 8'd0)
                cnt <= cnt - 8'd1;
            if (cfg_we) begin
                case (cfg_addr)
                    2'd0:    stg_erase   <= cfg_wdata;
                    2'd1:    stg_expose  <= cfg_wdata;
                    2'd2:    stg_convert <= cfg_wdata;
                    default: stg_read    <= cfg_wdata;
                endcase
            end
            if (frame_start) begin
                sh_expose  <= stg_expose;
                sh_convert <= stg_convert;
                sh_read    <= stg_read;
            end
            erase      <= (next_state == S_ERASE);
            expose     <= (next_state == S_EXPOSE);
            convert    <= (next_state == S_CONVERT);
            read       <= {next_state == S_READ4, next_state == S_READ3,
                           next_state == S_READ2, next_state == S_READ1};
            busy       <= (next_state != S_IDLE);
            frame_done <= done_next;
            if (done_next)
                frame_cnt <= frame_cnt + 8'd1;
        end
    end

`ifdef FRAME_SEQ_ADC_RAMP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            adc_count <= 8'd0;
        else if (frame_start)
            adc_count <= 8'd0;
        else if (next_state == S_CONVERT && adc_count != 8'hFF)
            adc_count <= adc_count + 8'd1;
    end
`else
    assign adc_count = 8'd0;
`endif

endmodule
